// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Clocked ALU with a {V,C,S,Z} status register. Logic, add/sub
//            and status ops complete in one cycle; shifts and rotates step
//            one bit per cycle, so latency is n+1 for an amount n >= 1.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 20,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam logic [3:0] c_OP_NOT = 4'd0;
    localparam logic [3:0] c_OP_AND = 4'd1;
    localparam logic [3:0] c_OP_OR  = 4'd2;
    localparam logic [3:0] c_OP_XOR = 4'd3;
    localparam logic [3:0] c_OP_INC = 4'd8;
    localparam logic [3:0] c_OP_DEC = 4'd9;
    localparam logic [3:0] c_OP_ADD = 4'd10;
    localparam logic [3:0] c_OP_ADC = 4'd11;
    localparam logic [3:0] c_OP_SUB = 4'd12;
    localparam logic [3:0] c_OP_SBB = 4'd13;
    localparam logic [3:0] c_OP_CMP = 4'd14;
    localparam logic [3:0] c_OP_XSR = 4'd15;

    localparam logic [SHW-1:0]   c_W   = SHW'(WIDTH);
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       kind_q, kind_d;

    logic             w_acc;
    logic             w_is_shift;
    logic [SHW-1:0]   w_n;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH-1:0] w_ab, w_sb;
    logic             w_acin, w_scin;
    logic [WIDTH:0]   w_sum, w_dif;
    logic             w_add_v, w_sub_v;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v;
    logic [3:0]       w_flg;
    logic [WIDTH-1:0] w_step;
    logic             w_out;

    assign in_ready  = (state_q != S_SHIFT);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

    assign w_acc      = in_valid && in_ready;
    assign w_is_shift = (op[3:2] == 2'b01);
    assign w_n        = b[SHW-1:0];
    // Rotates (op[1]=1) wrap the amount; shifts saturate it at WIDTH.
    assign w_amt      = op[1] ? (w_n % c_W) : ((w_n > c_W) ? c_W : w_n);

    // One shared adder (ADD/ADC/INC) and one subtractor (SUB/SBB/CMP/DEC).
    assign w_ab    = (op == c_OP_INC) ? c_ONE : b;
    assign w_acin  = (op == c_OP_ADC) ? flags_q[2] : 1'b0;
    assign w_sb    = (op == c_OP_DEC) ? c_ONE : b;
    assign w_scin  = (op == c_OP_SBB) ? flags_q[2] : 1'b0;
    assign w_sum   = {1'b0, a} + {1'b0, w_ab} + {{WIDTH{1'b0}}, w_acin};
    assign w_dif   = {1'b0, a} - {1'b0, w_sb} - {{WIDTH{1'b0}}, w_scin};
    assign w_add_v = (a[WIDTH-1] == w_ab[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_v = (a[WIDTH-1] != w_sb[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);

    // Result and flags of every op that finishes in the accept cycle.
    always_comb begin
        w_res = a;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            c_OP_NOT: w_res = ~a;
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_XOR: w_res = a ^ b;
            c_OP_INC, c_OP_ADD, c_OP_ADC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_add_v;
            end
            c_OP_DEC, c_OP_SUB, c_OP_SBB, c_OP_CMP: begin
                w_res = w_dif[WIDTH-1:0];
                w_c   = w_dif[WIDTH];
                w_v   = w_sub_v;
            end
            default: w_res = a;   // zero-amount shift/rotate and XSR pass a
        endcase
        if (op == c_OP_XSR) begin
            w_flg = flags_q ^ b[3:0];
        end else begin
            w_flg = {w_v, w_c, w_res[WIDTH-1], (w_res == '0)};
        end
    end

    // One-bit step of the working register; w_out is the bit leaving it.
    always_comb begin
        w_step = work_q;
        w_out  = 1'b0;
        case (kind_q)
            2'b00: begin w_step = {work_q[WIDTH-2:0], 1'b0};         w_out = work_q[WIDTH-1]; end
            2'b01: begin w_step = {1'b0, work_q[WIDTH-1:1]};         w_out = work_q[0];       end
            2'b10: begin w_step = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; w_out = work_q[WIDTH-1]; end
            default: begin w_step = {work_q[0], work_q[WIDTH-1:1]};  w_out = work_q[0];       end
        endcase
    end

    // Next-state logic: accept in IDLE/DONE, step bits in SHIFT.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (w_acc) begin
                    if (w_is_shift && (w_amt != '0)) begin
                        work_d  = a;
                        cnt_d   = w_amt;
                        kind_d  = op[1:0];
                        state_d = S_SHIFT;
                    end else begin
                        result_d = w_res;
                        flags_d  = w_flg;
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                work_d = w_step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    result_d = w_step;
                    flags_d  = {1'b0, w_out, w_step[WIDTH-1], (w_step == '0)};
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset abandons any shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            kind_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the 20-bit combinational ALU circuits.
- Accepts one operation per handshake and registers the result.
- Holds a 4-bit status register {V,C,S,Z} that carry-in ops and status ops read, and that every op updates.
- Multi-bit shifts and rotates run one bit per cycle, so the block has variable latency. It sits between the register file and the writeback/program-flow logic.

Parameters:
- WIDTH, 20, datapath width in bits (>= 4).
- SHW, $clog2(WIDTH)+1, width of the shift/rotate amount field taken from b[SHW-1:0].

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  op/a/b valid this cycle.
- in_ready  output  1  block can accept; high in IDLE and DONE, low in SHIFT.
- op  input  4  opcode (encoding below).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; for shifts/rotates, b[SHW-1:0] is the amount.
- out_valid  output  1  one-cycle pulse; result and flags are final.
- result  output  WIDTH  registered result; held until the next completion.
- flags  output  4  status register {V,C,S,Z} = flags[3:0].

Behaviour:
- Clock and reset: one clock (clk); synchronous, active-high reset (rst).
- Reset values: state=IDLE, result=0, flags=0, out_valid=0, in_ready=1. rst dominates in_valid.
- Reset mid-SHIFT abandons the op: no out_valid, flags untouched by it, and the block accepts again in the first cycle after rst falls.
- Accept occurs when in_valid && in_ready at a rising edge (edge T). in_valid while in_ready=0 is ignored; the source must hold.
- Opcodes: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 SHL, 5 SHR, 6 ROL, 7 ROR, 8 INC, 9 DEC, 10 ADD, 11 ADC, 12 SUB, 13 SBB, 14 CMP, 15 XSR.
- Single-cycle ops (all except 4-7):
  - result and flags are written at edge T; out_valid is high in cycle T+1.
  - A new accept in that same cycle is legal, giving back-to-back throughput of 1/cycle.
- Arithmetic, modulo 2^WIDTH:
  - INC = a+1; DEC = a-1 (b ignored).
  - ADC = a+b+C; SBB = a-b-C, where C is the status-register value at edge T, i.e. the previous op's C.
  - SUB/SBB/CMP: C=1 means unsigned borrow.
  - ADD/ADC/INC: C = carry out.
  - V = signed two's-complement overflow for ops 8-14.
  - CMP: result=a-b, flags as SUB.
- Logic ops 0-3: C=0, V=0.
- XSR: result=a; flags <= flags ^ b[3:0]. Z and S are NOT recomputed for XSR.
- Z = (result==0) and S = result[WIDTH-1] for every op except XSR.
- Shift/rotate, with n = b[SHW-1:0]:
  - Shifts clamp n to WIDTH. Rotates use n mod WIDTH.
  - n==0 completes like a single-cycle op: result=a, C=0, V=0.
  - n>=1: edge T loads the working reg and count and enters SHIFT. Edges T+1..T+n move one bit each. At edge T+n, result/flags are written and the FSM goes to DONE, so out_valid is high in cycle T+n+1. Latency = n+1 cycles.
  - C = the last bit shifted out (SHL: old msb; SHR: old lsb); for rotates, C = the last bit wrapped. V=0.
  - SHR is logical (zero fill).
- FSM:
  - IDLE -> (accept single-cycle or n==0) -> DONE.
  - IDLE -> (accept shift, n>=1) -> SHIFT.
  - SHIFT -> (count==1) -> DONE.
  - DONE -> (accept) as IDLE, else IDLE.
  - out_valid = (state==DONE).
- Flags are written only at completion. During SHIFT, flags hold their old value.

Test Plan:
- WIDTH=20. ADD a=0xFFFFF b=0x00001 -> cycle T+1: out_valid=1, result=0x00000, flags Z=1 C=1 S=0 V=0. Follow with ADC a=0 b=0 at T+1 -> result=0x00001, C=0.
- ADD 0x7FFFF+0x00001 -> result 0x80000, S=1 V=1 C=0. SUB 0x00000-0x00001 -> 0xFFFFF, C=1 S=1 V=0. CMP 5,5 -> Z=1, C=0.
- SHL a=0x00001 b=19 -> in_ready=0 for 19 cycles, out_valid at T+20, result 0x80000, C=0. SHL a=0x00001 b=20 -> result 0, C=1, Z=1, latency 21.
- ROR a=0x00001 b=1 -> result 0x80000, C=1, latency 2. ROL a=0x00001 b=25 -> rotate by 5 -> 0x00020, latency 6. SHR b=0 -> result=a at T+1.
- Hold in_valid with a new ADD during SHIFT -> not accepted until the out_valid cycle, then accepted; its result appears next cycle.
- Assert rst at 3rd SHIFT cycle -> next cycle result=0, flags=0, out_valid=0, in_ready=1; no stale out_valid. XSR b=0xF from flags=0 -> flags=0xF, result=a.
